// File: rtl/hazard_forward_unit.sv
// ID-stage operand forwarding with load-use stall detection and a counted hold
// FSM that paces branch/JR consumers resolving in ID.
module hazard_forward_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int EARLY_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_pipe_ready,
  input  logic [NUM_SRC*REG_AW-1:0]    i_src_addr,
  input  logic [NUM_SRC-1:0]           i_src_use,
  input  logic                         i_early_use,
  input  logic [NUM_STAGES-1:0]        i_stg_wen,
  input  logic [NUM_STAGES*REG_AW-1:0] i_stg_dst,
  input  logic [NUM_STAGES*DATA_W-1:0] i_stg_data,
  input  logic [NUM_STAGES-1:0]        i_stg_data_ok,
  output logic                         o_stall_loaduse,
  output logic                         o_early_ok,
  output logic [NUM_SRC-1:0]           o_fwd_valid,
  output logic [NUM_SRC*DATA_W-1:0]    o_fwd_data
);

  // state  | meaning
  // S_IDLE | no early consumer being held; early_ok = ~early_hazard
  // S_HOLD | early consumer waiting out r_cnt more pipe_ready cycles

  localparam int CNT_W = (EARLY_WAIT < 1) ? 1 : $clog2(EARLY_WAIT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [NUM_SRC-1:0]        r_fwd_valid;
  logic [NUM_SRC*DATA_W-1:0] r_fwd_data;

  logic [NUM_SRC-1:0]        w_win_found;
  logic [NUM_SRC-1:0]        w_win_ok;
  logic [NUM_SRC*DATA_W-1:0] w_win_data;
  logic                      w_any_hit;
  logic                      w_stall;
  logic                      w_early_hazard;
  logic                      w_early_ok;

  // Scan oldest to youngest so the youngest matching producer overwrites last.
  always_comb begin
    w_win_found = '0;
    w_win_ok    = '0;
    w_win_data  = '0;
    w_any_hit   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
        if (i_src_use[i] && i_stg_wen[j] &&
            (i_stg_dst[j*REG_AW +: REG_AW] != '0) &&
            (i_stg_dst[j*REG_AW +: REG_AW] == i_src_addr[i*REG_AW +: REG_AW])) begin
          w_win_found[i]                = 1'b1;
          w_win_ok[i]                   = i_stg_data_ok[j];
          w_win_data[i*DATA_W +: DATA_W] = i_stg_data[j*DATA_W +: DATA_W];
          w_any_hit                     = 1'b1;
        end
      end
      if (!(w_win_found[i] && w_win_ok[i])) begin
        w_win_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  assign w_stall        = |(w_win_found & ~w_win_ok);
  assign w_early_hazard = i_early_use & w_any_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fwd_valid <= '0;
      r_fwd_data  <= '0;
    end else if (i_pipe_ready) begin
      r_fwd_valid <= w_win_found & w_win_ok;
      r_fwd_data  <= w_win_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A flush (early_use dropped) leaves HOLD even while the pipe is frozen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_pipe_ready && w_early_hazard && !w_stall) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(EARLY_WAIT - 1);
        end
      end
      S_HOLD: begin
        if (!i_early_use) begin
          w_state_nxt = S_IDLE;
        end else if (i_pipe_ready) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_early_ok = 1'b1;
    case (r_state)
      S_IDLE:  w_early_ok = ~w_early_hazard;
      S_HOLD:  w_early_ok = (r_cnt == '0) | ~i_early_use;
      default: w_early_ok = 1'b1;
    endcase
  end

  assign o_stall_loaduse = w_stall;
  assign o_early_ok      = w_early_ok;
  assign o_fwd_valid     = r_fwd_valid;
  assign o_fwd_data      = r_fwd_data;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table with a forward-data scoreboard,
// plus hand sequences for the hold FSM (EARLY_WAIT = 1 and 3), freeze and reset.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_ready;
  logic [9:0]  src_addr;
  logic [1:0]  src_use;
  logic        early_use;
  logic [1:0]  wen;
  logic [9:0]  dst;
  logic [63:0] data;
  logic [1:0]  ok;

  logic        stall1, eok1, stall3, eok3;
  logic [1:0]  fv1, fv3;
  logic [63:0] fd1, fd3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.EARLY_WAIT(1)) u_dut_w1 (
    .clk(clk), .reset_n(reset_n), .i_pipe_ready(pipe_ready),
    .i_src_addr(src_addr), .i_src_use(src_use), .i_early_use(early_use),
    .i_stg_wen(wen), .i_stg_dst(dst), .i_stg_data(data), .i_stg_data_ok(ok),
    .o_stall_loaduse(stall1), .o_early_ok(eok1), .o_fwd_valid(fv1), .o_fwd_data(fd1)
  );

  hazard_forward_unit #(.EARLY_WAIT(3)) u_dut_w3 (
    .clk(clk), .reset_n(reset_n), .i_pipe_ready(pipe_ready),
    .i_src_addr(src_addr), .i_src_use(src_use), .i_early_use(early_use),
    .i_stg_wen(wen), .i_stg_dst(dst), .i_stg_data(data), .i_stg_data_ok(ok),
    .o_stall_loaduse(stall3), .o_early_ok(eok3), .o_fwd_valid(fv3), .o_fwd_data(fd3)
  );

  typedef struct {
    string       name;
    logic [9:0]  src_addr;
    logic [1:0]  src_use;
    logic        early_use;
    logic [1:0]  wen;
    logic [9:0]  dst;
    logic [63:0] data;
    logic [1:0]  ok;
    logic        exp_stall;
    logic        exp_early;
    logic [1:0]  exp_fv;
    logic [63:0] exp_fd;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  fv;
    logic [63:0] fd;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    src_addr  = v.src_addr;
    src_use   = v.src_use;
    early_use = v.early_use;
    wen       = v.wen;
    dst       = v.dst;
    data      = v.data;
    ok        = v.ok;
  endtask

  task automatic hazard_inputs();
    src_addr  = {5'd0, 5'd5};
    src_use   = 2'b01;
    early_use = 1'b1;
    wen       = 2'b10;
    dst       = {5'd5, 5'd0};
    data      = {32'h0000BBBB, 32'h0};
    ok        = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_t e;
    logic exp1[5];
    logic exp3[5];
    logic exp3b[4];

    vecs[0]  = '{"fwd_young",   {5'd0,5'd5}, 2'b01, 1'b0, 2'b11, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b11, 1'b0, 1'b1, 2'b01, {32'h0,32'h0000AAAA}};
    vecs[1]  = '{"stall_young", {5'd0,5'd5}, 2'b01, 1'b0, 2'b11, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b10, 1'b1, 1'b1, 2'b00, 64'h0};
    vecs[2]  = '{"stall_clear", {5'd0,5'd5}, 2'b01, 1'b0, 2'b11, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b11, 1'b0, 1'b1, 2'b01, {32'h0,32'h0000AAAA}};
    vecs[3]  = '{"r0_never",    {5'd0,5'd0}, 2'b10, 1'b0, 2'b01, {5'd0,5'd0},
                 {32'h0,32'h00001234}, 2'b11, 1'b0, 1'b1, 2'b00, 64'h0};
    vecs[4]  = '{"same_addr",   {5'd7,5'd7}, 2'b11, 1'b0, 2'b11, {5'd7,5'd3},
                 {32'h0000CCCC,32'h00003333}, 2'b11, 1'b0, 1'b1, 2'b11, {32'h0000CCCC,32'h0000CCCC}};
    vecs[5]  = '{"old_not_ok",  {5'd7,5'd7}, 2'b11, 1'b0, 2'b11, {5'd7,5'd3},
                 {32'h0000CCCC,32'h00003333}, 2'b01, 1'b1, 1'b1, 2'b00, 64'h0};
    vecs[6]  = '{"wen_off",     {5'd0,5'd5}, 2'b01, 1'b0, 2'b10, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b11, 1'b0, 1'b1, 2'b01, {32'h0,32'h0000BBBB}};
    vecs[7]  = '{"use_off",     {5'd5,5'd5}, 2'b00, 1'b0, 2'b11, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b00, 1'b0, 1'b1, 2'b00, 64'h0};
    vecs[8]  = '{"cross",       {5'd4,5'd9}, 2'b11, 1'b0, 2'b11, {5'd9,5'd4},
                 {32'h00009999,32'h00004444}, 2'b11, 1'b0, 1'b1, 2'b11, {32'h00004444,32'h00009999}};
    vecs[9]  = '{"early_stall", {5'd0,5'd5}, 2'b01, 1'b1, 2'b01, {5'd0,5'd5},
                 {32'h0,32'h0000AAAA}, 2'b00, 1'b1, 1'b0, 2'b00, 64'h0};
    vecs[10] = '{"early_nohit", {5'd0,5'd6}, 2'b01, 1'b1, 2'b11, {5'd5,5'd5},
                 {32'h0000BBBB,32'h0000AAAA}, 2'b11, 1'b0, 1'b1, 2'b00, 64'h0};

    reset_n = 1'b0; pipe_ready = 1'b1;
    src_addr = '0; src_use = '0; early_use = 1'b0; wen = '0; dst = '0; data = '0; ok = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_valid", fv1, 2'b00);
    chk("rst_fwd_data", fd1, 64'h0);
    chk("rst_early_ok", eok1, 1'b1);
    chk("rst_stall", stall1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      apply(vecs[k]);
      #1;
      chk({vecs[k].name, "_stall"}, stall1, vecs[k].exp_stall);
      chk({vecs[k].name, "_early_ok"}, eok1, vecs[k].exp_early);
      sb.push_back('{vecs[k].name, vecs[k].exp_fv, vecs[k].exp_fd});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_fwd_valid"}, fv1, e.fv);
        chk({e.name, "_fwd_data"}, fd1, e.fd);
        chk({e.name, "_fwd_valid_w3"}, fv3, e.fv);
        chk({e.name, "_fwd_data_w3"}, fd3, e.fd);
      end
    end

    // Early consumer, hazard in stage 1, pipe running.
    exp1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hazard_inputs();
      #1;
      chk($sformatf("hold_w1_c%0d", k), eok1, exp1[k]);
      chk($sformatf("hold_w3_c%0d", k), eok3, exp3[k]);
    end

    // Flush out of HOLD while frozen.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      early_use = 1'b0; pipe_ready = 1'b0;
      #1;
      chk($sformatf("flush_w1_c%0d", k), eok1, 1'b1);
    end

    @(negedge clk);
    hazard_inputs(); pipe_ready = 1'b1;
    #1;
    chk("enter_w1", eok1, 1'b0);
    chk("enter_w3", eok3, 1'b0);

    // Freeze mid-HOLD: counter, early_ok and forwarded data must hold.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pipe_ready = 1'b0;
      data = {32'h0000DDDD, 32'h0};
      #1;
      chk($sformatf("freeze_w1_eok_c%0d", k), eok1, 1'b1);
      chk($sformatf("freeze_w3_eok_c%0d", k), eok3, 1'b0);
      chk($sformatf("freeze_fv_c%0d", k), fv1, 2'b01);
      chk($sformatf("freeze_fd_c%0d", k), fd3, {32'h0, 32'h0000BBBB});
    end

    @(negedge clk);
    hazard_inputs(); pipe_ready = 1'b1;
    #1;
    chk("resume_w3", eok3, 1'b0);

    // Reset while the EARLY_WAIT=3 instance is mid-HOLD.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midhold_rst_fv", fv3, 2'b00);
    chk("midhold_rst_fd", fd3, 64'h0);
    chk("midhold_rst_w3_eok", eok3, 1'b0);
    chk("midhold_rst_w1_eok", eok1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    exp3b = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("post_rst_w3_c%0d", k), eok3, exp3b[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
